// File: rtl/opcode_sequencer_pkg.sv
// Shared decode definitions: opcode encodings, sequencer states and opcode classifiers.
// Imported by the opcode sequencer and the control unit.
package opcode_sequencer_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OP_W-1:0] OP_CALL  = 5'b11000;
  localparam logic [OP_W-1:0] OP_CALL2 = 5'b11001;
  localparam logic [OP_W-1:0] OP_RET   = 5'b11010;
  localparam logic [OP_W-1:0] OP_RET2  = 5'b11011;
  localparam logic [OP_W-1:0] OP_RTI   = 5'b11100;
  localparam logic [OP_W-1:0] OP_RTI2  = 5'b11101;
  localparam logic [OP_W-1:0] OP_INT1  = 5'b11110;
  localparam logic [OP_W-1:0] OP_INT2  = 5'b11111;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    SECOND = 2'd1,
    INT2   = 2'd2
  } seq_state_e;

  // First half of a two-part instruction; its second half is always op+1.
  function automatic logic is_pair_first(input logic [OP_W-1:0] op);
    return (op == OP_CALL) || (op == OP_RET) || (op == OP_RTI);
  endfunction

  // Second halves and interrupt opcodes may only be generated internally.
  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return (op == OP_CALL2) || (op == OP_RET2) || (op == OP_RTI2) ||
           (op == OP_INT1)  || (op == OP_INT2);
  endfunction

endpackage

// File: rtl/opcode_sequencer.sv
// Decode-stage opcode register: passes single-cycle opcodes, expands CALL/RET/RTI
// into opcode pairs and injects the two-part interrupt sequence at instruction boundaries.
module opcode_sequencer
  import opcode_sequencer_pkg::*;
#(
  parameter int              OPW    = 5,
  parameter logic [OPW-1:0]  NOP_OP = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] fetchOpCode,
  input  logic           fetchValid,
  input  logic           intReq,
  input  logic           hold,
  input  logic           flush,
  output logic [OPW-1:0] opCode,
  output logic           fetchStall,
  output logic           intAck,
  output logic           intPending,
  output logic           illegalOp
);

  seq_state_e     state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [OPW-1:0] second_q, second_d;
  logic           int_ack_q, int_ack_d;
  logic           int_pending_q, int_pending_d;
  logic           illegal_q, illegal_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    second_d      = second_q;
    int_ack_d     = int_ack_q;
    illegal_d     = illegal_q;
    // A request is latched even under hold; repeats while pending merge into one.
    int_pending_d = int_pending_q | intReq;

    if (!hold) begin
      int_ack_d = 1'b0;
      illegal_d = 1'b0;
      case (state_q)
        PASS: begin
          if (int_pending_q) begin
            opcode_d  = OPW'(OP_INT1);
            int_ack_d = 1'b1;
            state_d   = INT2;
          end else if (!fetchValid || flush) begin
            opcode_d = NOP_OP;
          end else if (is_pair_first(OP_W'(fetchOpCode))) begin
            opcode_d = fetchOpCode;
            second_d = fetchOpCode + OPW'(1);
            state_d  = SECOND;
          end else if (is_reserved(OP_W'(fetchOpCode))) begin
            opcode_d  = NOP_OP;
            illegal_d = 1'b1;
          end else begin
            opcode_d = fetchOpCode;
          end
        end
        SECOND: begin
          opcode_d = second_q;
          state_d  = PASS;
        end
        INT2: begin
          opcode_d      = OPW'(OP_INT2);
          state_d       = PASS;
          int_pending_d = 1'b0;
        end
        default: begin
          opcode_d = NOP_OP;
          state_d  = PASS;
        end
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q      <= NOP_OP;
      int_ack_q     <= 1'b0;
      int_pending_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      opcode_q      <= opcode_d;
      int_ack_q     <= int_ack_d;
      int_pending_q <= int_pending_d;
      illegal_q     <= illegal_d;
    end
  end

  // Second-part opcode is pure data: only meaningful after a first part loads it.
  always_ff @(posedge clk) begin
    second_q <= second_d;
  end

  assign fetchStall = hold | (state_q != PASS) | int_pending_q;
  assign opCode     = opcode_q;
  assign intAck     = int_ack_q;
  assign intPending = int_pending_q;
  assign illegalOp  = illegal_q;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Self-checking bench for opcode_sequencer: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based reference model.
module tb_opcode_sequencer;

  logic       clk;
  logic       rst;
  logic [4:0] fetchOpCode;
  logic       fetchValid;
  logic       intReq;
  logic       hold;
  logic       flush;
  logic [4:0] opCode;
  logic       fetchStall;
  logic       intAck;
  logic       intPending;
  logic       illegalOp;

  int n_checks = 0;
  int n_errors = 0;

  opcode_sequencer #(.OPW(5), .NOP_OP(5'b00000)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetchOpCode(fetchOpCode),
    .fetchValid (fetchValid),
    .intReq     (intReq),
    .hold       (hold),
    .flush      (flush),
    .opCode     (opCode),
    .fetchStall (fetchStall),
    .intAck     (intAck),
    .intPending (intPending),
    .illegalOp  (illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       fv;
    logic [4:0] op;
    logic       ir;
    logic       hold;
    logic       flush;
    logic       cs;      // check fetchStall before the edge
    logic       es;
    logic [4:0] eop;
    logic       eack;
    logic       epend;
    logic       eill;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic fv, input logic [4:0] op,
                       input logic ir, input logic h, input logic fl);
    rst = r; fetchValid = fv; fetchOpCode = op; intReq = ir; hold = h; flush = fl;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] eop, input logic eack,
                            input logic epend, input logic eill);
    chk({nm, ".opCode"},     8'(opCode),     8'(eop));
    chk({nm, ".intAck"},     8'(intAck),     8'(eack));
    chk({nm, ".intPending"}, 8'(intPending), 8'(epend));
    chk({nm, ".illegalOp"},  8'(illegalOp),  8'(eill));
  endtask

  // Apply one cycle: drive, check the combinational stall, clock, then check outputs.
  task automatic cyc(input string nm, input logic r, input logic fv, input logic [4:0] op,
                     input logic ir, input logic h, input logic fl, input logic es,
                     input logic [4:0] eop, input logic eack, input logic epend,
                     input logic eill);
    drive(r, fv, op, ir, h, fl);
    #1;
    chk({nm, ".fetchStall"}, 8'(fetchStall), 8'(es));
    @(posedge clk);
    #1;
    expect_out(nm, eop, eack, epend, eill);
  endtask

  function automatic vec_t mk(logic r, logic fv, logic [4:0] op, logic ir, logic h,
                              logic fl, logic cs, logic es, logic [4:0] eop,
                              logic eack, logic epend, logic eill);
    vec_t v;
    v.rst = r; v.fv = fv; v.op = op; v.ir = ir; v.hold = h; v.flush = fl;
    v.cs = cs; v.es = es; v.eop = eop; v.eack = eack; v.epend = epend; v.eill = eill;
    return v;
  endfunction

  // Reference model: a queue of opcodes owed to the control unit before the next
  // fetch may be consumed, plus a pending-interrupt flag.
  logic [4:0] m_owed[$];
  logic       m_int;
  logic [4:0] m_op;
  logic       m_ack;
  logic       m_ill;

  function automatic logic m_stall(input logic h);
    return h || (m_owed.size() != 0) || m_int;
  endfunction

  task automatic m_update(input logic r, input logic fv, input logic [4:0] op,
                          input logic ir, input logic h, input logic fl);
    logic took_int2;
    if (r) begin
      m_owed.delete();
      m_int = 0; m_op = 5'd0; m_ack = 0; m_ill = 0;
    end else if (h) begin
      if (ir) m_int = 1;
    end else begin
      took_int2 = 0;
      m_ack = 0; m_ill = 0;
      if (m_owed.size() != 0) begin
        m_op = m_owed.pop_front();
        took_int2 = (m_op == 5'd31);
      end else if (m_int) begin
        m_op = 5'd30; m_ack = 1;
        m_owed.push_back(5'd31);
      end else if (!fv || fl) begin
        m_op = 5'd0;
      end else if (op == 5'd24 || op == 5'd26 || op == 5'd28) begin
        m_op = op;
        m_owed.push_back(op + 5'd1);
      end else if (op == 5'd25 || op == 5'd27 || op >= 5'd29) begin
        m_op = 5'd0; m_ill = 1;
      end else begin
        m_op = op;
      end
      m_int = (m_int || ir) && !took_int2;
    end
  endtask

  initial begin
    drive(1'b1, 1'b1, 5'b01001, 1'b0, 1'b0, 1'b0);

    // Reset, pass-through, CALL pair, illegal and flush vectors.
    tbl.push_back(mk(1,1,5'b01001,0,0,0, 0,0, 5'b00000,0,0,0));
    tbl.push_back(mk(1,1,5'b01001,0,0,0, 1,0, 5'b00000,0,0,0));
    tbl.push_back(mk(0,1,5'b01001,0,0,0, 1,0, 5'b01001,0,0,0));
    tbl.push_back(mk(0,1,5'b01010,0,0,0, 1,0, 5'b01010,0,0,0));
    tbl.push_back(mk(0,1,5'b11000,0,0,0, 1,0, 5'b11000,0,0,0));
    tbl.push_back(mk(0,1,5'b01001,0,0,0, 1,1, 5'b11001,0,0,0));
    tbl.push_back(mk(0,1,5'b01001,0,0,0, 1,0, 5'b01001,0,0,0));
    tbl.push_back(mk(0,1,5'b11111,0,0,0, 1,0, 5'b00000,0,0,1));
    tbl.push_back(mk(0,1,5'b01001,0,0,1, 1,0, 5'b00000,0,0,0));
    tbl.push_back(mk(0,1,5'b11001,0,0,0, 1,0, 5'b00000,0,0,1));
    tbl.push_back(mk(0,1,5'b11001,0,1,0, 1,1, 5'b00000,0,0,1));
    tbl.push_back(mk(0,0,5'b00111,0,0,0, 1,0, 5'b00000,0,0,0));
    tbl.push_back(mk(0,1,5'b00111,0,0,0, 1,0, 5'b00111,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].fv, tbl[i].op, tbl[i].ir, tbl[i].hold, tbl[i].flush);
      #1;
      if (tbl[i].cs) chk($sformatf("vec%0d.fetchStall", i), 8'(fetchStall), 8'(tbl[i].es));
      @(posedge clk);
      #1;
      expect_out($sformatf("vec%0d", i), tbl[i].eop, tbl[i].eack, tbl[i].epend, tbl[i].eill);
    end

    // Interrupt arriving with RET: pair completes, then 11110/11111, then the held op.
    cyc("int_ret0", 0,1,5'b11010,1,0,0, 0, 5'b11010,0,1,0);
    cyc("int_ret1", 0,1,5'b01001,0,0,0, 1, 5'b11011,0,1,0);
    cyc("int_ret2", 0,1,5'b01001,0,0,0, 1, 5'b11110,1,1,0);
    cyc("int_ret3", 0,1,5'b01001,0,0,1, 1, 5'b11111,0,0,0);
    cyc("int_ret4", 0,1,5'b01001,0,0,0, 0, 5'b01001,0,0,0);

    // Hold during the SECOND cycle of RTI: second part issued exactly once after release.
    cyc("rti_hold0", 0,1,5'b11100,0,0,0, 0, 5'b11100,0,0,0);
    for (int k = 0; k < 3; k++)
      cyc($sformatf("rti_hold%0d", k + 1), 0,1,5'b01010,0,1,0, 1, 5'b11100,0,0,0);
    cyc("rti_hold4", 0,1,5'b01010,0,0,0, 1, 5'b11101,0,0,0);
    cyc("rti_hold5", 0,1,5'b01010,0,0,0, 0, 5'b01010,0,0,0);

    // Interrupt held while pending under hold; intAck stays through hold.
    cyc("int_hold0", 0,1,5'b00011,1,1,0, 1, 5'b01010,0,1,0);
    cyc("int_hold1", 0,1,5'b00011,0,0,0, 1, 5'b11110,1,1,0);
    cyc("int_hold2", 0,1,5'b00011,1,1,0, 1, 5'b11110,1,1,0);
    cyc("int_hold3", 0,1,5'b00011,0,0,0, 1, 5'b11111,0,0,0);
    cyc("int_hold4", 0,1,5'b00011,0,0,0, 0, 5'b00011,0,0,0);

    // Reset in the middle of the interrupt sequence.
    cyc("rst_int0", 0,1,5'b01001,1,0,0, 0, 5'b01001,0,1,0);
    cyc("rst_int1", 0,1,5'b01001,0,0,0, 1, 5'b11110,1,1,0);
    cyc("rst_int2", 1,1,5'b01001,0,1,0, 1, 5'b00000,0,0,0);
    cyc("rst_int3", 0,1,5'b01001,0,0,0, 0, 5'b01001,0,0,0);

    // Randomized traffic against the reference model.
    m_update(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      logic r, fv, ir, h, fl;
      logic [4:0] op;
      r  = ($urandom_range(0, 99) == 0);
      fv = ($urandom_range(0, 7) != 0);
      ir = ($urandom_range(0, 9) == 0);
      h  = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 7) == 0);
      op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(24, 31))
                                       : 5'($urandom_range(0, 31));
      drive(r, fv, op, ir, h, fl);
      #1;
      chk("rnd.fetchStall", 8'(fetchStall), 8'(m_stall(h)));
      @(posedge clk);
      m_update(r, fv, op, ir, h, fl);
      #1;
      expect_out("rnd", m_op, m_ack, m_int, m_ill);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
